// File: rtl/sfx_noise_gen.sv
// sfx_noise_gen: multi-channel LFSR noise source with octave counter, clock-source select and one-shot gate
// Ports:
//   soundclk       system clock
//   rst_n          synchronous active-low reset
//   strobe_i       shared external timebase, rising edge is a tick
//   src_sel_i      per channel: 0 = external strobe, 1 = internal divider
//   div_i          per-channel divider reload, channel c at [c*DIV_W +: DIV_W]
//   trig_i         per-channel gate trigger, rising edge loads the gate
//   gate_len_i     per-channel gate length in ticks, 0 keeps the gate off
//   lfsr_bit_o     raw feedback bit lfsr[TAP_A]^lfsr[TAP_B]
//   noise_o        octave counter MSB
//   gate_o         gate active
//   noise_gated_o  noise_o & gate_o
module sfx_noise_gen #(
    parameter int NUM_CH = 2,
    parameter int LFSR_W = 24,
    parameter int TAP_A  = 23,
    parameter int TAP_B  = 10,
    parameter int DIV_W  = 16,
    parameter int OCT_W  = 3,
    parameter int GATE_W = 12
) (
    input  logic                     soundclk,
    input  logic                     rst_n,
    input  logic                     strobe_i,
    input  logic [NUM_CH-1:0]        src_sel_i,
    input  logic [NUM_CH*DIV_W-1:0]  div_i,
    input  logic [NUM_CH-1:0]        trig_i,
    input  logic [NUM_CH*GATE_W-1:0] gate_len_i,
    output logic [NUM_CH-1:0]        lfsr_bit_o,
    output logic [NUM_CH-1:0]        noise_o,
    output logic [NUM_CH-1:0]        gate_o,
    output logic [NUM_CH-1:0]        noise_gated_o
);
    logic              strobe_d;
    logic [NUM_CH-1:0] trig_d;
    logic              ext_tick;

    assign ext_tick = strobe_i & ~strobe_d;

    // Delayed copies reset high so an input held high through reset is not seen as an edge
    always_ff @(posedge soundclk)
        if (!rst_n) begin
            strobe_d <= 1'b1;
            trig_d   <= '1;
        end else begin
            strobe_d <= strobe_i;
            trig_d   <= trig_i;
        end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [LFSR_W-1:0] lfsr;
        logic              prev_bit;
        logic [OCT_W-1:0]  oct_cnt;
        logic [GATE_W-1:0] gate_cnt;
        logic [DIV_W-1:0]  div_cnt;
        logic              fb;
        logic              int_tick;
        logic              tick;
        logic              trig_rise;

        assign fb        = lfsr[TAP_A] ^ lfsr[TAP_B];
        // >= keeps the wait short when the reload is lowered mid-count
        assign int_tick  = div_cnt >= div_i[c*DIV_W +: DIV_W];
        assign tick      = src_sel_i[c] ? int_tick : ext_tick;
        assign trig_rise = trig_i[c] & ~trig_d[c];

        always_ff @(posedge soundclk)
            if (!rst_n) begin
                lfsr     <= '0;
                prev_bit <= 1'b0;
                oct_cnt  <= '0;
                gate_cnt <= '0;
                div_cnt  <= '0;
            end else begin
                div_cnt <= int_tick ? '0 : div_cnt + DIV_W'(1);
                if (tick) begin
                    // XNOR feedback: all-zero is a legal state, all-ones is the unreachable lock-up
                    lfsr     <= {lfsr[LFSR_W-2:0], ~fb};
                    prev_bit <= fb;
                    if (!prev_bit && fb)
                        oct_cnt <= oct_cnt + OCT_W'(1);
                end
                if (trig_rise)
                    gate_cnt <= gate_len_i[c*GATE_W +: GATE_W];
                else if (tick && gate_cnt != '0)
                    gate_cnt <= gate_cnt - GATE_W'(1);
            end

        assign lfsr_bit_o[c]    = fb;
        assign noise_o[c]       = oct_cnt[OCT_W-1];
        assign gate_o[c]        = |gate_cnt;
        assign noise_gated_o[c] = oct_cnt[OCT_W-1] & (|gate_cnt);
    end
endmodule

// File: tb/tb_sfx_noise_gen.sv
// tb_sfx_noise_gen: scoreboard bench for sfx_noise_gen with directed stimulus and a per-channel reference model
module tb_sfx_noise_gen;
    logic        soundclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strobe = 1'b0;
    logic [1:0]  src_sel = 2'b00;
    logic [31:0] div = '0;
    logic [1:0]  trig = 2'b00;
    logic [23:0] gate_len = '0;
    logic [1:0]  lfsr_bit, noise, gate, noise_gated;

    sfx_noise_gen dut (
        .soundclk(soundclk), .rst_n(rst_n), .strobe_i(strobe), .src_sel_i(src_sel),
        .div_i(div), .trig_i(trig), .gate_len_i(gate_len), .lfsr_bit_o(lfsr_bit),
        .noise_o(noise), .gate_o(gate), .noise_gated_o(noise_gated)
    );

    always #5 soundclk = ~soundclk;

    typedef struct {
        int         cyc;
        string      nm;
        logic [7:0] m;
        logic [7:0] e;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        done = 1'b0;
    logic        checked = 1'b0;

    logic [23:0] ml[2];
    logic        mp[2];
    logic [2:0]  mo[2];
    logic [11:0] mg[2];

    always @(posedge soundclk) cyc <= cyc + 1;

    // Monitor: outputs packed as {noise_gated, gate, noise, lfsr_bit}
    always @(negedge soundclk) begin
        logic [7:0] act;
        exp_t e;
        act = {noise_gated, gate, noise, lfsr_bit};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if ((act & e.m) !== (e.e & e.m)) begin
                bad++;
                $display("FAIL %s cyc=%0d act=%h req=%h mask=%h", e.nm, cyc, act & e.m, e.e & e.m, e.m);
            end
        end
        if (done && !checked) begin
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL drain left=%0d req=0", sb.size());
            end
            checked = 1'b1;
        end
    end

    task automatic push(input string nm, input logic [7:0] m, input logic [7:0] e);
        exp_t x;
        x.cyc = cyc; x.nm = nm; x.m = m; x.e = e;
        sb.push_back(x);
    endtask

    function automatic logic [7:0] model_out();
        logic [1:0] lb, n, g;
        for (int c = 0; c < 2; c++) begin
            lb[c] = ml[c][23] ^ ml[c][10];
            n[c]  = mo[c][2];
            g[c]  = mg[c] != 0;
        end
        return {n & g, g, n, lb};
    endfunction

    task automatic step();
        @(posedge soundclk);
        #1;
    endtask

    // One clock: tk/ld are the hand-determined ticks and trigger loads at this edge
    task automatic clk1(input logic [1:0] tk, input logic [1:0] ld, input string nm);
        step();
        for (int c = 0; c < 2; c++) begin
            logic fb;
            fb = ml[c][23] ^ ml[c][10];
            if (ld[c]) mg[c] = gate_len[c*12 +: 12];
            else if (tk[c] && mg[c] != 0) mg[c] = mg[c] - 12'd1;
            if (tk[c]) begin
                if (!mp[c] && fb) mo[c] = mo[c] + 3'd1;
                mp[c] = fb;
                ml[c] = {ml[c][22:0], ~fb};
            end
        end
        push(nm, 8'hFF, model_out());
    endtask

    task automatic pulse(input string nm);
        strobe = 1'b1;
        clk1(2'b11, 2'b00, nm);
        strobe = 1'b0;
        clk1(2'b00, 2'b00, nm);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        for (int c = 0; c < 2; c++) begin
            ml[c] = '0; mp[c] = 1'b0; mo[c] = '0; mg[c] = '0;
        end
        push("reset", 8'hFF, 8'h00);
        step();
        push("reset_hold", 8'hFF, 8'h00);
        rst_n = 1'b1;
    endtask

    task automatic run_from_reset(input int n, input string nm);
        clk1(2'b00, 2'b00, "idle");
        for (int i = 1; i <= n; i++) begin
            pulse(nm);
            if (i == 10) push("lfsr_t10", 8'h03, 8'h00);
            if (i == 11) push("lfsr_t11", 8'h03, 8'h03);
            if (i == 12) push("oct_t12", 8'h0F, 8'h03);
        end
    endtask

    initial begin
        // Strobe-driven LFSR sequence from reset, both channels
        do_reset();
        run_from_reset(4096, "lfsr_model");

        // Divider: ch0 div=4 then lowered to 1 with div_cnt=3, ch1 div=0 ticks every cycle
        src_sel = 2'b11;
        div = {16'd0, 16'd4};
        do_reset();
        for (int k = 0; k <= 40; k++) begin
            logic t0;
            if (k == 13) div[15:0] = 16'd1;
            t0 = (k < 13) ? (k % 5 == 4) : ((k - 13) % 2 == 0);
            clk1({1'b1, t0}, 2'b00, "divider");
        end

        // Strobe held high through reset, then a 10-cycle high gives one tick; gate len 1 exposes it
        src_sel = 2'b00;
        div = '0;
        strobe = 1'b1;
        gate_len = {12'd0, 12'd1};
        do_reset();
        clk1(2'b00, 2'b00, "strobe_rst_high");
        trig = 2'b11;
        clk1(2'b00, 2'b11, "trig_load1");
        for (int k = 0; k < 5; k++) clk1(2'b00, 2'b00, "strobe_held");
        strobe = 1'b0;
        clk1(2'b00, 2'b00, "strobe_low");
        strobe = 1'b1;
        clk1(2'b11, 2'b00, "strobe_rise");
        for (int k = 0; k < 9; k++) clk1(2'b00, 2'b00, "strobe_high10");
        strobe = 1'b0;
        trig = 2'b00;
        clk1(2'b00, 2'b00, "strobe_fall");

        // Gate: len 3, retrigger after 2 ticks, trigger coinciding with a tick; ch1 len 0 stays off
        gate_len = {12'd0, 12'd3};
        trig = 2'b11;
        clk1(2'b00, 2'b11, "gate_load");
        trig = 2'b00;
        push("gate_on", 8'h30, 8'h10);
        pulse("gate_tick");
        pulse("gate_tick");
        trig = 2'b11;
        clk1(2'b00, 2'b11, "gate_retrig");
        trig = 2'b00;
        for (int k = 0; k < 4; k++) pulse("gate_run");
        push("gate_off", 8'h30, 8'h00);
        trig = 2'b11;
        strobe = 1'b1;
        clk1(2'b11, 2'b11, "gate_load_on_tick");
        strobe = 1'b0;
        trig = 2'b00;
        clk1(2'b00, 2'b00, "gate_after_load");
        pulse("gate_t1");
        pulse("gate_t2");
        push("gate_still_on", 8'h30, 8'h10);
        pulse("gate_t3");
        push("gate_expired", 8'h30, 8'h00);
        pulse("gate_idle");

        // Reset mid-run with gate active and oct_cnt = 5
        src_sel = 2'b11;
        gate_len = {12'd4095, 12'd4095};
        trig = 2'b11;
        clk1(2'b11, 2'b11, "fast_load");
        trig = 2'b00;
        for (int k = 0; k < 5000 && mo[0] != 3'd5; k++) clk1(2'b11, 2'b00, "fast_run");
        if (mo[0] != 3'd5) push("oct5_timeout", 8'hFF, ~model_out());
        push("pre_reset_active", 8'h30, 8'h30);
        src_sel = 2'b00;
        do_reset();
        run_from_reset(16, "restart");

        done = 1'b1;
        step();
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
